// File: rtl/tape_ram_writer_if.sv
// Bundles the tape parser, RAM write port and CPU loader signals of tape_ram_writer.
// The checksum wire exists only when TAPE_RAM_WRITER_CHECKSUM_EN is defined.
interface tape_ram_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] tape_addr;
    logic              tape_wr;
    logic [DATA_W-1:0] tape_dout;
    logic              tape_complete;
    logic              ram_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_we;
    logic              exec_req;
    logic [ADDR_W-1:0] exec_addr;
    logic              exec_ack;
    logic              busy;
    logic              overflow;
`ifdef TAPE_RAM_WRITER_CHECKSUM_EN
    logic [7:0]        checksum;

    modport slave (
        input  tape_addr, tape_wr, tape_dout, tape_complete, ram_ready, exec_ack,
        output ram_addr, ram_dout, ram_we, exec_req, exec_addr, busy, overflow, checksum
    );
    modport master (
        output tape_addr, tape_wr, tape_dout, tape_complete, ram_ready, exec_ack,
        input  ram_addr, ram_dout, ram_we, exec_req, exec_addr, busy, overflow, checksum
    );
`else
    modport slave (
        input  tape_addr, tape_wr, tape_dout, tape_complete, ram_ready, exec_ack,
        output ram_addr, ram_dout, ram_we, exec_req, exec_addr, busy, overflow
    );
    modport master (
        output tape_addr, tape_wr, tape_dout, tape_complete, ram_ready, exec_ack,
        input  ram_addr, ram_dout, ram_we, exec_req, exec_addr, busy, overflow
    );
`endif
endinterface

// File: rtl/tape_ram_writer.sv
// Converts level-style tape parser writes into one FIFO-buffered RAM write per byte,
// then hands the exec address to the loader. Optional checksum: TAPE_RAM_WRITER_CHECKSUM_EN.
module tape_ram_writer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 3
) (
    input logic             clk,
    input logic             reset_n,
    tape_ram_writer_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, LOADING, DRAIN, EXEC_REQ} state_t;
    typedef logic [FIFO_AW:0] ptr_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              wr_seen_q, wr_seen_d;
    logic              cmpl_prev_q, cmpl_prev_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] exec_addr_q, exec_addr_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];

    logic              capture, cmpl_rise, empty, full, pop, push, drop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign capture   = bus.tape_wr && (!wr_seen_q || bus.tape_addr != last_addr_q);
    assign cmpl_rise = bus.tape_complete && !cmpl_prev_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop       = !empty && bus.ram_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign push      = capture && (!full || pop);
    assign drop      = capture && !push;
    assign {head_addr, head_data} = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_comb begin
        wr_seen_d   = bus.tape_wr;
        last_addr_d = capture ? bus.tape_addr : last_addr_q;
        cmpl_prev_d = bus.tape_complete;
        wr_ptr_d    = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    end

    always_comb begin
        state_d     = state_q;
        exec_addr_d = exec_addr_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (cmpl_rise) begin
                    exec_addr_d = bus.tape_addr;
                    state_d     = DRAIN;
                end else if (capture) begin
                    state_d = LOADING;
                end
            end
            LOADING: begin
                if (cmpl_rise) begin
                    exec_addr_d = bus.tape_addr;
                    state_d     = DRAIN;
                end
            end
            DRAIN:    if (empty && !pop) state_d = EXEC_REQ;
            EXEC_REQ: if (bus.exec_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Any capture seen from IDLE starts a fresh load; a drop in that same cycle still counts.
        if (state_q == IDLE && capture) overflow_d = 1'b0;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_addr_q <= '0;
            wr_seen_q   <= 1'b0;
            cmpl_prev_q <= 1'b0;
            overflow_q  <= 1'b0;
            exec_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_addr_q <= last_addr_d;
            wr_seen_q   <= wr_seen_d;
            cmpl_prev_q <= cmpl_prev_d;
            overflow_q  <= overflow_d;
            exec_addr_q <= exec_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: outputs are gated by pop and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {bus.tape_addr, bus.tape_dout};
    end

    assign bus.ram_we    = pop;
    assign bus.ram_addr  = pop ? head_addr : '0;
    assign bus.ram_dout  = pop ? head_data : '0;
    assign bus.exec_req  = (state_q == EXEC_REQ);
    assign bus.exec_addr = exec_addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overflow  = overflow_q;

`ifdef TAPE_RAM_WRITER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        // Writes during EXEC_REQ belong to the next load; the reported sum stays frozen.
        if (pop && state_q != EXEC_REQ) sum_d = sum_q + 8'(head_data);
        if (state_q == IDLE && state_d == LOADING) sum_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign bus.checksum = sum_q;
`endif
endmodule
